// File: rtl/kyo_sprite_pkg.sv
// Shared constants and types for the Kyo sprite fetch/palette path.
// stand_pixel() holds the standing-pose artwork as a pure function of ROM address.
package kyo_sprite_pkg;

    localparam int SPR_W       = 64;
    localparam int SPR_H       = 112;
    localparam int NUM_FRAMES  = 6;
    localparam int FRAME_HOLD  = 6;
    localparam int FRAME_WORDS = SPR_W * SPR_H;
    localparam int ADDR_W      = $clog2(NUM_FRAMES * FRAME_WORDS);
    localparam int FRAME_W     = $clog2(NUM_FRAMES);
    localparam int HOLD_W      = $clog2(FRAME_HOLD);

    typedef logic [3:0]        pal_idx_t;
    typedef logic [ADDR_W-1:0] spr_addr_t;

    localparam pal_idx_t TRANSPARENT_IDX = 4'h0;

    // Stand-in for the converted sprite image: a dense index pattern that
    // still contains transparent pixels, so the keying path is exercised.
    function automatic pal_idx_t stand_pixel(input spr_addr_t a);
        return pal_idx_t'(32'(a) * 32'd5 + 32'(a >> 6) * 32'd3
                        + 32'(a >> 13) * 32'd7 + 32'd9);
    endfunction

endpackage

// File: rtl/kyo_stand_rom.sv
// Synchronous single-port ROM holding the stand animation, 4-bit palette indices.
module kyo_stand_rom
    import kyo_sprite_pkg::*;
(
    input  logic      clk,
    input  logic      en,
    input  spr_addr_t addr,
    output pal_idx_t  data
);

    always_ff @(posedge clk) begin
        if (en)
            data <= stand_pixel(addr);
    end

endmodule

// File: rtl/kyo_stand_sprite_fetch.sv
// Kyo standing-pose sprite fetch: per-frame shadowed position/animation, 2-stage ROM pipe.
// Optional mirroring is built only when KYO_STAND_FLIP_EN is defined.
module kyo_stand_sprite_fetch
    import kyo_sprite_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset,
    input  logic               pix_en,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    input  logic               frame_tick,
    input  logic [9:0]         pos_x,
    input  logic [9:0]         pos_y,
    input  logic               facing_left,
    input  logic               anim_en,
    output pal_idx_t           index,
    output logic               opaque,
    output logic [FRAME_W-1:0] anim_frame
);

    logic [9:0]        shx, shy;
    logic [HOLD_W-1:0] hold;

    // Position and animation only change at vsync so a frame never tears.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            shx        <= '0;
            shy        <= '0;
            hold       <= '0;
            anim_frame <= '0;
        end else if (frame_tick) begin
            shx <= pos_x;
            shy <= pos_y;
            if (anim_en) begin
                if (hold == HOLD_W'(FRAME_HOLD - 1)) begin
                    hold       <= '0;
                    anim_frame <= (anim_frame == FRAME_W'(NUM_FRAMES - 1))
                                  ? '0 : anim_frame + FRAME_W'(1);
                end else begin
                    hold <= hold + HOLD_W'(1);
                end
            end
        end
    end

    logic signed [10:0] rx, ry;
    logic               in_box;
    logic [9:0]         col;
    spr_addr_t          addr_nxt;

    assign rx = $signed({1'b0, DrawX}) - $signed({1'b0, shx});
    assign ry = $signed({1'b0, DrawY}) - $signed({1'b0, shy});

    assign in_box = !rx[10] && (rx[9:0] < 10'(SPR_W))
                 && !ry[10] && (ry[9:0] < 10'(SPR_H));

`ifdef KYO_STAND_FLIP_EN
    logic shf;

    always_ff @(posedge Clk) begin
        if (Reset)
            shf <= 1'b0;
        else if (frame_tick)
            shf <= facing_left;
    end

    assign col = shf ? 10'(SPR_W - 1) - rx[9:0] : rx[9:0];
`else
    logic unused_facing;

    assign unused_facing = facing_left;
    assign col           = rx[9:0];
`endif

    // Out-of-box addresses are junk but harmless: the valid bit masks them.
    assign addr_nxt = spr_addr_t'(32'(anim_frame) * FRAME_WORDS
                                + 32'(ry[9:0]) * SPR_W + 32'(col));

    logic [1:0] vld_pipe;
    spr_addr_t  addr;
    pal_idx_t   rom_data;

    always_ff @(posedge Clk) begin
        if (Reset)
            vld_pipe <= '0;
        else if (pix_en)
            vld_pipe <= {vld_pipe[0], in_box};
    end

    always_ff @(posedge Clk) begin
        if (pix_en)
            addr <= addr_nxt;
    end

    kyo_stand_rom u_rom (
        .clk  (Clk),
        .en   (pix_en),
        .addr (addr),
        .data (rom_data)
    );

    assign index  = vld_pipe[1] ? rom_data : TRANSPARENT_IDX;
    assign opaque = vld_pipe[1] && (rom_data != TRANSPARENT_IDX);

endmodule

// File: tb/tb_kyo_stand_sprite_fetch.sv
// Directed plus randomized bench for kyo_stand_sprite_fetch against a behavioural model.
module tb_kyo_stand_sprite_fetch;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic       pix_en = 1'b0;
    logic [9:0] DrawX = '0, DrawY = '0;
    logic       frame_tick = 1'b0;
    logic [9:0] pos_x = 10'd100, pos_y = 10'd50;
    logic       facing_left = 1'b0;
    logic       anim_en = 1'b0;
    logic [3:0] index;
    logic       opaque;
    logic [2:0] anim_frame;

    always #5 clk = ~clk;

    kyo_stand_sprite_fetch dut (
        .Clk         (clk),
        .Reset       (Reset),
        .pix_en      (pix_en),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .frame_tick  (frame_tick),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .facing_left (facing_left),
        .anim_en     (anim_en),
        .index       (index),
        .opaque      (opaque),
        .anim_frame  (anim_frame)
    );

    int checks = 0, passes = 0, fails = 0;

    // Model state: shadows, mirror flag, count of enabled ticks, in-flight pixels.
    int m_sx = 0, m_sy = 0, m_f = 0, m_ticks = 0;
    int q[$];

    function automatic int romval(int a);
        return (a * 5 + (a / 64) * 3 + (a / 8192) * 7 + 9) % 16;
    endfunction

    function automatic int model_pix(int x, int y);
        int rx, ry, col, frame;
        rx = x - m_sx;
        ry = y - m_sy;
        if (rx < 0 || rx >= 64 || ry < 0 || ry >= 112) return 0;
        col   = (m_f != 0) ? 63 - rx : rx;
        frame = (m_ticks / 6) % 6;
        return romval((frame * 7168 + ry * 64 + col) % 65536);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit pix, input int x, input int y, input bit tick);
        int exp;
        pix_en     = pix;
        DrawX      = 10'(x);
        DrawY      = 10'(y);
        frame_tick = tick;
        @(posedge clk);
        if (Reset) begin
            q.delete();
            m_sx = 0; m_sy = 0; m_f = 0; m_ticks = 0;
        end else begin
            if (pix) begin
                q.push_back(model_pix(x, y));
                if (q.size() > 2) void'(q.pop_front());
            end
            if (tick) begin
                m_sx = int'(pos_x);
                m_sy = int'(pos_y);
`ifdef KYO_STAND_FLIP_EN
                m_f = int'(facing_left);
`else
                m_f = 0;
`endif
                if (anim_en) m_ticks++;
            end
        end
        #1;
        exp = (q.size() == 2) ? q[0] : 0;
        check("index", 32'(index), 32'(exp));
        check("opaque", 32'(opaque), 32'(exp != 0));
        check("anim_frame", 32'(anim_frame), 32'((m_ticks / 6) % 6));
    endtask

    initial begin
        // Reset wins over a coincident tick and pixel enable.
        step(1, 100, 50, 1);
        step(1, 100, 50, 1);
        check("reset_index", 32'(index), 32'd0);
        Reset = 1'b0;

        // Latch 100/50, then the sprite origin and right-edge boundary.
        step(0, 0, 0, 1);
        step(1, 100, 50, 0);
        step(1, 163, 50, 0);
        check("rom0", 32'(index), 32'(romval(0)));
        check("rom0_opaque", 32'(opaque), 32'(romval(0) != 0));
        step(1, 164, 50, 0);
        check("rom63", 32'(index), 32'(romval(63)));
        step(1, 0, 0, 0);
        check("x164_index", 32'(index), 32'd0);
        check("x164_opaque", 32'(opaque), 32'd0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // Animation sequencing, wrap, then freeze.
        anim_en = 1'b1;
        for (int i = 1; i <= 36; i++) begin
            step(0, 0, 0, 1);
            if (i == 5) check("anim_before6", 32'(anim_frame), 32'd0);
            if (i == 6) check("anim_after6", 32'(anim_frame), 32'd1);
        end
        check("anim_wrap", 32'(anim_frame), 32'd0);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 1);
        anim_en = 1'b0;
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1);
        check("anim_frozen", 32'(anim_frame), 32'd1);

        // Position change takes effect only at the next tick.
        pos_x = 10'd200;
        step(1, 100, 50, 0);
        step(1, 0, 0, 0);
        check("old_pos", 32'(index), 32'(romval(7168)));
        step(0, 0, 0, 1);
        step(1, 200, 50, 0);
        step(1, 0, 0, 0);
        check("new_pos", 32'(index), 32'(romval(7168)));

        // Tick coincident with a pixel step uses the old shadow.
        pos_x = 10'd100;
        step(1, 200, 50, 1);
        step(1, 100, 50, 0);
        check("tick_old_shadow", 32'(index), 32'(romval(7168)));
        step(1, 0, 0, 0);
        check("tick_new_shadow", 32'(index), 32'(romval(7168)));

        // Mirroring.
        facing_left = 1'b1;
        step(0, 0, 0, 1);
        step(1, 100, 50, 0);
        step(1, 0, 0, 0);
`ifdef KYO_STAND_FLIP_EN
        check("mirror", 32'(index), 32'(romval(7168 + 63)));
`else
        check("mirror", 32'(index), 32'(romval(7168)));
`endif
        facing_left = 1'b0;
        step(0, 0, 0, 1);

        // Randomized scan with occasional ticks and re-positioning.
        for (int i = 0; i < 400; i++) begin
            bit tk;
            tk = ($urandom % 20) == 0;
            if (tk) begin
                pos_x       = 10'(80 + $urandom % 60);
                pos_y       = 10'(40 + $urandom % 40);
                facing_left = 1'($urandom);
                anim_en     = ($urandom % 3) != 0;
            end
            step(($urandom % 4) != 0, int'(60 + $urandom % 150), int'(30 + $urandom % 150), tk);
        end

        // Reset mid-line during a stalled cycle, then refill.
        step(1, 110, 60, 0);
        step(0, 0, 0, 0);
        Reset = 1'b1;
        step(0, 0, 0, 0);
        check("midreset_index", 32'(index), 32'd0);
        check("midreset_opaque", 32'(opaque), 32'd0);
        Reset = 1'b0;
        step(1, 5, 5, 0);
        check("refill_1", 32'(index), 32'd0);
        step(0, 0, 0, 0);
        step(1, 6, 5, 0);
        check("refill_2", 32'(index), 32'(romval(5 * 64 + 5)));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/kyo_stand_sprite_fetch.md
Name: kyo_stand_sprite_fetch

Overview:
- Upstream stage of the Kyo standing-pose palette lookup. For each pixel on the scan (DrawX, DrawY), it fetches the 4-bit colour index from the stand-animation sprite ROM and drives it to the palette.
- Owns the animation frame sequencing and the sprite screen position. Both are captured once per video frame so a drawn frame never tears.
- Produces a registered index plus an opaque flag. Index 0 (magenta key) is transparent.

Parameters:
- SPR_W, 64, sprite width in pixels
- SPR_H, 112, sprite height in pixels
- NUM_FRAMES, 6, animation frames stored back-to-back in ROM
- FRAME_HOLD, 6, video frames each animation frame is shown
- ADDR_W, $clog2(NUM_FRAMES*SPR_W*SPR_H), ROM address width (derived)

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- pix_en  in  1  pixel-rate enable; the pipeline advances only when high
- DrawX  in  10  current scan column
- DrawY  in  10  current scan row
- frame_tick  in  1  one-Clk pulse at vsync start
- pos_x  in  10  requested sprite top-left column
- pos_y  in  10  requested sprite top-left row
- facing_left  in  1  mirror request
- anim_en  in  1  animation advance enable
- index  out  4  palette index for the pixel 2 pix_en cycles back
- opaque  out  1  1 when the sprite covers that pixel and index is non-zero
- anim_frame  out  $clog2(NUM_FRAMES)  currently displayed animation frame

Behaviour:
- Reset (synchronous, Clk edge with Reset=1):
  - index=0, opaque=0, anim_frame=0.
  - Hold counter=0; shadow pos_x/pos_y/facing=0; all pipeline valid bits=0.
  - Reset takes priority over frame_tick and pix_en.
- Frame-tick handling (independent of pix_en):
  - On frame_tick, shadow registers capture pos_x, pos_y and facing_left.
  - If anim_en=1, the hold counter increments. When it reaches FRAME_HOLD-1, it clears to 0 and anim_frame advances. anim_frame wraps from NUM_FRAMES-1 to 0.
  - If anim_en=0, the hold counter and anim_frame freeze; the shadows still update.
  - A new anim_frame value is first used for addressing on the Clk after the tick.
- Stage 0 (on pix_en):
  - rx = DrawX - shadow_x and ry = DrawY - shadow_y, computed as 11-bit signed values.
  - in_box = (0 <= rx < SPR_W) && (0 <= ry < SPR_H). A sprite partly off-screen is simply clipped; negative differences are outside.
  - col = facing ? SPR_W-1-rx : rx.
  - addr = anim_frame*SPR_W*SPR_H + ry*SPR_W + col, truncated to ADDR_W.
  - Register addr and v0 = in_box.
- Stage 1 (on pix_en): the ROM reads addr synchronously; v1 <= v0.
- Output (on pix_en):
  - index = v1 ? rom_data : 0.
  - opaque = v1 && rom_data != 0.
- Latency and stalls:
  - Latency is exactly 2 pix_en-qualified cycles from DrawX/DrawY to index.
  - With pix_en=0, all pipeline registers and outputs hold.
- Boundary cases:
  - rx = SPR_W-1 is inside; rx = SPR_W is outside.
  - frame_tick coincident with pix_en: the pipeline step uses the old shadows; the new shadows apply from the next Clk.
  - Reset asserted mid-line: outputs are 0 on the next Clk. After release, the first valid index appears 2 pix_en cycles later.

Optional Feature:
- Macro: KYO_STAND_FLIP_EN.
- Defined: facing_left is captured into the shadow and mirrors columns as described above.
- Undefined: facing_left is ignored, the shadow facing is constant 0, and the mirror subtractor is not built; col = rx always.

Decomposition:
- Shared package kyo_sprite_pkg:
  - Constants: SPR_W, SPR_H, NUM_FRAMES, FRAME_HOLD, TRANSPARENT_IDX=4'h0.
  - typedef pal_idx_t (logic [3:0]).
  - typedef spr_addr_t.
- Sub-module kyo_stand_rom:
  - Synchronous single-port ROM, 4-bit words, initialised from the stand sprite memory file.
  - The only instance in this block.
- The palette stays a separate downstream module; index connects directly to its index input.

Test Plan:
- Reset release, shadow_x=100, shadow_y=50, scan DrawX=100, DrawY=50 -> index equals ROM[0] exactly 2 pix_en cycles later; opaque=(ROM[0]!=0).
- DrawX=163 then 164 with shadow_x=100 -> 163 returns ROM[63], 164 returns index=0 and opaque=0.
- anim_en=1, FRAME_HOLD=6: apply 6 frame_ticks -> anim_frame goes 0->1 on the 6th. After 36 ticks it wraps back to 0. With anim_en=0 across 10 ticks, anim_frame stays constant.
- pos_x changed from 100 to 200 mid-frame, no frame_tick -> pixels still fetched relative to 100. After the next frame_tick, relative to 200.
- KYO_STAND_FLIP_EN defined, facing_left=1 latched, DrawX=shadow_x -> index=ROM[63] (mirrored column). Same stimulus with the macro undefined -> ROM[0].
- pix_en toggling 1-0-1 with Reset pulsed during a 0 cycle -> index=0 and opaque=0 on the Clk after Reset; the pipeline refills and the first valid output is 2 pix_en cycles after release.
